// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU op encodings and default widths.
package id_ex_stage_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultRegAw = 5;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSub  = 4'b0011,
    AluSlt  = 4'b0100,
    AluDiv  = 4'b0101,
    AluZero = 4'b0110,
    AluMul  = 4'b0111,
    AluXor  = 4'b1111
  } alu_op_e;

  // A bubble drives the ALU with its zero op so nothing meaningful is computed.
  localparam alu_op_e BubbleOp = AluZero;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Operand forwarding select: MEM result, else WB result, else registered data.
// Register 0 is never forwarded.
module id_ex_stage_operand_fwd #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_data
);

  logic rs_nonzero;
  logic mem_hit;
  logic wb_hit;

  assign rs_nonzero = (rs_addr != '0);
  assign mem_hit    = mem_reg_write && (mem_rd_addr == rs_addr) && rs_nonzero;
  assign wb_hit     = wb_reg_write && (wb_rd_addr == rs_addr) && rs_nonzero;

  // MEM holds the younger producer, so it wins over WB.
  always_comb begin
    fwd_data = reg_data;
    if (mem_hit) begin
      fwd_data = mem_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, stall and flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned REG_AW = DefaultRegAw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              reg_write_q, reg_write_d;

  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;

  id_ex_stage_operand_fwd #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (rs1_fwd)
  );

  id_ex_stage_operand_fwd #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (rs2_fwd)
  );

  // Next-state select: flush > stall (hold, refresh operands) > load; invalid load is a bubble.
  always_comb begin
    valid_d     = valid_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_op_d    = alu_op_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    if (flush || (!stall && !id_valid)) begin
      valid_d     = 1'b0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      use_imm_d   = 1'b0;
      alu_op_d    = BubbleOp;
      rd_addr_d   = '0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      // Latch forwarded values so a producer retiring during the stall is not lost.
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end else begin
      valid_d     = 1'b1;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      use_imm_d   = id_use_imm;
      alu_op_d    = id_alu_op;
      rd_addr_d   = id_rd_addr;
      reg_write_d = id_reg_write;
    end
  end

  // Pipeline register; reset leaves a bubble in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= BubbleOp;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign op1           = rs1_fwd;
  assign op2           = use_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign op            = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write;
  logic        stall;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_alu_op     (id_alu_op),
    .id_rd_addr    (id_rd_addr),
    .id_reg_write  (id_reg_write),
    .stall         (stall),
    .flush         (flush),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .ex_valid      (ex_valid),
    .op1           (op1),
    .op2           (op2),
    .op            (op),
    .ex_store_data (ex_store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic ui, input logic [3:0] aop,
                          input logic [4:0] rd, input logic rw);
    id_valid     = v;
    id_rs1_addr  = rs1;
    id_rs1_data  = d1;
    id_rs2_addr  = rs2;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_use_imm   = ui;
    id_alu_op    = aop;
    id_rd_addr   = rd;
    id_reg_write = rw;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0;
    mem_rd_addr   = '0;
    mem_result    = '0;
    wb_reg_write  = 1'b0;
    wb_rd_addr    = '0;
    wb_result     = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0);
    clear_fwd();

    // Reset state
    #12;
    check("rst_valid", 32'(ex_valid), 32'h0);
    check("rst_op", 32'(op), 32'h6);
    check("rst_op1", op1, 32'h0);
    check("rst_op2", op2, 32'h0);
    check("rst_store", ex_store_data, 32'h0);
    check("rst_regwr", 32'(ex_reg_write), 32'h0);

    // Release reset while idle: still a bubble
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(ex_valid), 32'h0);
    check("idle_op", 32'(op), 32'h6);
    check("idle_op1", op1, 32'h0);

    // Plain load
    drive_id(1'b1, 5'd3, 32'h10, 5'd4, 32'h20, 32'h0, 1'b0, 4'b0010, 5'd9, 1'b1);
    tick();
    check("load_op1", op1, 32'h10);
    check("load_op2", op2, 32'h20);
    check("load_op", 32'(op), 32'h2);
    check("load_valid", 32'(ex_valid), 32'h1);
    check("load_rd", 32'(ex_rd_addr), 32'd9);
    check("load_regwr", 32'(ex_reg_write), 32'h1);
    check("load_store", ex_store_data, 32'h20);

    // Invalid decode slot loads a bubble
    id_valid = 1'b0;
    tick();
    check("bub_valid", 32'(ex_valid), 32'h0);
    check("bub_op", 32'(op), 32'h6);
    check("bub_rd", 32'(ex_rd_addr), 32'h0);

    // Forwarding priority (combinational, between edges)
    drive_id(1'b1, 5'd5, 32'h1, 5'd6, 32'h2, 32'h0, 1'b0, 4'b0011, 5'd8, 1'b1);
    tick();
    id_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'hAA;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd5; wb_result  = 32'hBB;
    #1;
    check("fwd_mem_pri", op1, 32'hAA);
    check("fwd_op2_nohit", op2, 32'h2);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_wb", op1, 32'hBB);
    mem_reg_write = 1'b1; mem_rd_addr = 5'd6;
    #1;
    check("fwd_indep_op1", op1, 32'hBB);
    check("fwd_indep_op2", op2, 32'hAA);
    check("fwd_indep_st", ex_store_data, 32'hAA);
    clear_fwd();
    #1;
    check("fwd_none", op1, 32'h1);

    // Register zero never forwarded
    drive_id(1'b1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'b0010, 5'd1, 1'b1);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hFF;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hEE;
    #1;
    check("r0_op1", op1, 32'h0);
    check("r0_op2", op2, 32'h0);
    clear_fwd();

    // Stall refresh: WB value captured during stall survives WB going idle
    drive_id(1'b1, 5'd1, 32'h11, 5'd7, 32'h77, 32'h0, 1'b0, 4'b0000, 5'd3, 1'b1);
    tick();
    check("st_pre_op2", op2, 32'h77);
    stall = 1'b1;
    drive_id(1'b1, 5'd2, 32'h5555, 5'd2, 32'h5555, 32'h8, 1'b1, 4'b0111, 5'd4, 1'b0);
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'h1234;
    #1;
    check("st_fwd_op2", op2, 32'h1234);
    tick();
    clear_fwd();
    #1;
    check("st_hold_op2", op2, 32'h1234);
    check("st_hold_op", 32'(op), 32'h0);
    check("st_hold_op1", op1, 32'h11);
    tick();
    check("st2_op2", op2, 32'h1234);
    check("st2_valid", 32'(ex_valid), 32'h1);
    check("st2_rd", 32'(ex_rd_addr), 32'd3);

    // Immediate selects OP2 while store data keeps the forwarded rs2
    stall = 1'b0;
    drive_id(1'b1, 5'd1, 32'h11, 5'd7, 32'h0, 32'h8, 1'b1, 4'b0010, 5'd5, 1'b1);
    tick();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_result = 32'h1234;
    #1;
    check("imm_op2", op2, 32'h8);
    check("imm_store", ex_store_data, 32'h1234);
    clear_fwd();

    // Flush beats stall
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("fl_valid", 32'(ex_valid), 32'h0);
    check("fl_regwr", 32'(ex_reg_write), 32'h0);
    check("fl_op", 32'(op), 32'h6);
    check("fl_rd", 32'(ex_rd_addr), 32'h0);
    check("fl_op1", op1, 32'h0);
    stall = 1'b0;
    flush = 1'b0;

    // Asynchronous reset mid-instruction
    drive_id(1'b1, 5'd3, 32'hCAFE, 5'd4, 32'hBEEF, 32'h0, 1'b0, 4'b1111, 5'd6, 1'b1);
    tick();
    check("ar_pre_valid", 32'(ex_valid), 32'h1);
    check("ar_pre_op", 32'(op), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ex_valid), 32'h0);
    check("ar_op", 32'(op), 32'h6);
    check("ar_op1", op1, 32'h0);
    check("ar_op2", op2, 32'h0);
    check("ar_regwr", 32'(ex_reg_write), 32'h0);

    // Capture resumes on the first edge with reset released
    rst_n = 1'b1;
    tick();
    check("rel_op1", op1, 32'hCAFE);
    check("rel_valid", 32'(ex_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
